// File: rtl/uart_tx_mmio_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register
// offsets (word index within the 16-byte window), STATUS bit positions
// and the transmit FSM state encoding.
package uart_tx_mmio_pkg;

    localparam logic [1:0] REG_TXDATA   = 2'd0;
    localparam logic [1:0] REG_STATUS   = 2'd1;
    localparam logic [1:0] REG_CTRL     = 2'd2;
    localparam logic [1:0] REG_BAUD_DIV = 2'd3;

    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_BUSY    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;
    localparam int STAT_CNT_W   = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/tx_fifo.sv
// Small synchronous FIFO. Pointers carry one extra wrap bit so that full
// and empty are distinguishable without a separate counter. A push while
// full and a pop while empty are ignored.
module tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign count     = wr_ptr_r - rd_ptr_r;
    assign rdata     = mem_r[rd_ptr_r[AW-1:0]];
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Advance read/write pointers; reset discards all queued entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Storage array write; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/uart_tx_mmio_responder.sv
// Data-bus target exposing a 16-byte register window in front of an 8N1
// UART transmitter. Stores to TXDATA queue bytes; the FSM drains them as
// back-to-back frames. Reads are side-effect free and combinational.
module uart_tx_mmio_responder
    import uart_tx_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR        = 32'h1001_0040,
    parameter int          FIFO_DEPTH       = 4,
    parameter logic [15:0] DEFAULT_BAUD_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address_i,
    input  logic [31:0] write_data_i,
    input  logic        mem_write_i,
    input  logic        mem_read_i,
    output logic        hit_o,
    output logic [31:0] data_o,
    output logic        serial_tx_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic            hit_s;
    logic [1:0]      offset_s;
    logic            wr_en_s;
    logic            push_s;
    logic            pop_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic [CW-1:0]   fifo_count_s;
    logic [7:0]      fifo_head_s;
    logic            bit_end_s;
    logic            frame_go_s;
    logic [31:0]     rdata_s;
    logic [31:0]     status_s;
    logic            unused_bits_s;
    tx_state_e       state_r;
    tx_state_e       state_next_s;

    logic            enable_r;
    logic [15:0]     baud_div_r;
    logic            overflow_r;
    logic [7:0]      shift_r;
    logic [2:0]      bit_idx_r;
    logic [15:0]     baud_cnt_r;
    logic [15:0]     div_work_r;
    logic            serial_tx_r;

    assign hit_s         = (address_i[31:4] == BASE_ADDR[31:4]);
    assign offset_s      = address_i[3:2];
    assign wr_en_s       = mem_write_i & hit_s;
    assign push_s        = wr_en_s & (offset_s == REG_TXDATA);
    assign bit_end_s     = (baud_cnt_r == (div_work_r - 16'd1));
    assign frame_go_s    = enable_r & ~fifo_empty_s;
    assign unused_bits_s = ^{address_i[1:0], write_data_i[31:16]};

    assign status_s = {23'd0,
                       STAT_CNT_W'(fifo_count_s),
                       overflow_r,
                       (state_r != ST_IDLE),
                       fifo_empty_s,
                       fifo_full_s};

    assign hit_o       = hit_s;
    assign data_o      = rdata_s;
    assign serial_tx_o = serial_tx_r;

    tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .wdata (write_data_i[7:0]),
        .pop   (pop_s),
        .rdata (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Register file updates from bus stores; overflow is sticky until cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            enable_r   <= 1'b1;
            baud_div_r <= DEFAULT_BAUD_DIV;
            overflow_r <= 1'b0;
        end else if (wr_en_s) begin
            case (offset_s)
                REG_TXDATA: begin
                    if (fifo_full_s) begin
                        overflow_r <= 1'b1;
                    end
                end
                REG_STATUS: begin
                    if (write_data_i[STAT_OVF]) begin
                        overflow_r <= 1'b0;
                    end
                end
                REG_CTRL: begin
                    enable_r <= write_data_i[0];
                end
                REG_BAUD_DIV: begin
                    baud_div_r <= (write_data_i[15:0] == 16'd0) ? 16'd1 : write_data_i[15:0];
                end
                default: begin
                    enable_r <= enable_r;
                end
            endcase
        end
    end

    // Read mux: zero unless this window is addressed by a load.
    always_comb begin
        rdata_s = 32'd0;
        if (hit_s && mem_read_i) begin
            case (offset_s)
                REG_TXDATA:   rdata_s = 32'd0;
                REG_STATUS:   rdata_s = status_s;
                REG_CTRL:     rdata_s = {31'd0, enable_r};
                REG_BAUD_DIV: rdata_s = {16'd0, baud_div_r};
                default:      rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    // Transmit FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a pop marks every frame start, including the
    // stop-to-start hand-off that keeps consecutive frames gap-free.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (frame_go_s) begin
                    state_next_s = ST_START;
                    pop_s        = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_next_s = ST_DATA;
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s && (bit_idx_r == 3'd7)) begin
                    state_next_s = ST_STOP;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (bit_end_s && frame_go_s) begin
                    state_next_s = ST_START;
                    pop_s        = 1'b1;
                end else if (bit_end_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Bit timing, shift register and registered line driver.
    always_ff @(posedge clk) begin
        if (reset) begin
            serial_tx_r <= 1'b1;
            shift_r     <= 8'd0;
            bit_idx_r   <= 3'd0;
            baud_cnt_r  <= 16'd0;
            div_work_r  <= DEFAULT_BAUD_DIV;
        end else if (pop_s) begin
            shift_r     <= fifo_head_s;
            div_work_r  <= baud_div_r;
            baud_cnt_r  <= 16'd0;
            bit_idx_r   <= 3'd0;
            serial_tx_r <= 1'b0;
        end else if (state_r == ST_IDLE) begin
            serial_tx_r <= 1'b1;
            baud_cnt_r  <= 16'd0;
        end else if (bit_end_s) begin
            baud_cnt_r <= 16'd0;
            case (state_r)
                ST_START: serial_tx_r <= shift_r[0];
                ST_DATA: begin
                    if (bit_idx_r == 3'd7) begin
                        serial_tx_r <= 1'b1;
                    end else begin
                        serial_tx_r <= shift_r[1];
                        shift_r     <= {1'b0, shift_r[7:1]};
                        bit_idx_r   <= bit_idx_r + 3'd1;
                    end
                end
                default: serial_tx_r <= 1'b1;
            endcase
        end else begin
            baud_cnt_r <= baud_cnt_r + 16'd1;
        end
    end

endmodule

// File: doc/uart_tx_mmio_responder.md
# uart_tx_mmio_responder

Memory-mapped responder on the processor's data-memory bus, the target-side counterpart to the processor's load/store initiator. It decodes a 16-byte window, holds bytes written by `sw` in a small FIFO, and serialises them as 8N1 UART frames. A `lw` from the window returns status and control words. The top level uses `hit_o` to steer `data_o` into the mem-to-reg path in place of data-RAM output.

## Interface
Parameters:
- BASE_ADDR, 32'h1001_0040, window base; must be 16-byte aligned.
- FIFO_DEPTH, 4, TX FIFO entries; must be a power of two, 2..16.
- DEFAULT_BAUD_DIV, 16'd434, clock cycles per bit after reset.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  reset; one clock; synchronous, active-high.
- address_i  in  32  byte address from ALU result.
- write_data_i  in  32  store data (rt).
- mem_write_i  in  1  store strobe.
- mem_read_i  in  1  load strobe.
- hit_o  out  1  combinational; high when address_i[31:4] == BASE_ADDR[31:4].
- data_o  out  32  combinational read data. It is 0 when there is no hit or mem_read_i is low.
- serial_tx_o  out  1  UART line, registered. Idle level is 1.

## Operation
- Register offsets are address_i[3:2]; address_i[1:0] is ignored.
  - 0x0 TXDATA: a write pushes write_data_i[7:0]. A read returns 0.
  - 0x4 STATUS (read-only except bit 3): bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits[8:4] count. Writing 1 to bit3 clears it.
  - 0x8 CTRL: bit0 enable; reset value 1.
  - 0xC BAUD_DIV: bits[15:0]. Writing 0 stores 1.
- Reads have no side effects.
- If mem_read_i and mem_write_i are both high, the write is performed and data_o shows the pre-write value.
- Push to a full FIFO: the byte is dropped and overflow is set. Full is evaluated before any same-cycle pop.
- Transmit FSM states: IDLE, START, DATA, STOP.
  - IDLE → START when enable is 1 and the FIFO is not empty. On that edge: pop the head byte into the shift register and latch BAUD_DIV into a working divisor.
  - START: line is 0 for one bit period, then → DATA.
  - DATA: 8 bits, LSB first, each held one bit period; a 3-bit index counts them. After bit 7 → STOP.
  - STOP: line is 1 for one bit period. At the end of the period: → START (with a new pop and latch) if enable is 1 and the FIFO is not empty, otherwise → IDLE.
- A bit period is exactly the latched divisor count of cycles. The baud counter reloads at every bit boundary.
- Clearing enable mid-frame: the current frame completes, then the FSM stays in IDLE.
- A BAUD_DIV write mid-frame takes effect at the next frame start.

## Timing
- Reset values: serial_tx_o=1, FSM=IDLE, FIFO empty, overflow=0, enable=1, BAUD_DIV=DEFAULT_BAUD_DIV, baud counter=0.
- hit_o and data_o are purely combinational from address_i, mem_read_i and register state, so single-cycle `lw` works.
- A store is committed at the rising edge where mem_write_i & hit_o are high. STATUS reflects it in the following cycle.
- Latency, for a write at edge N into an empty FIFO while IDLE and enabled:
  - edge N+1: START entered; serial_tx_o goes 0.
  - Frame lasts 10·div cycles; serial_tx_o returns to 1 at edge N+1+9·div.
- Back-to-back frames have no idle gap between stop bit and next start bit.
- Simultaneous push and pop when not full: both happen and count is unchanged.
- Reset mid-frame: serial_tx_o is 1 from the reset edge. FIFO contents and the partial frame are discarded.
- Pointer wrap: read and write pointers are log2(FIFO_DEPTH)+1 bits. Full means MSBs differ and the rest is equal.

## Structure
- Package `uart_tx_mmio_pkg`:
  - register offset constants (TXDATA, STATUS, CTRL, BAUD_DIV);
  - STATUS bit positions;
  - FSM state encoding (2 bits).
- Sub-module `tx_fifo`: synchronous FIFO with push, pop, full, empty and count. Parameters are width 8 and FIFO_DEPTH.
- The top module contains the address decode, register file, read mux, baud counter, shift register and FSM.

## Test plan
- Reset, then read STATUS at 0x1001_0044 → data_o=32'h0000_0002, serial_tx_o=1. Read 0x1001_0050 → hit_o=0, data_o=0.
- Write BAUD_DIV=4, then write 0x55 to TXDATA → line shows 0,1,0,1,0,1,0,1,0,1, each held 4 cycles. Start bit begins the edge after the write; 40-cycle frame.
- Clear enable, write 5 bytes 0x01..0x05 → STATUS count=4, full=1, overflow=1; line stays 1. Write 0x8 to STATUS → overflow=0.
- Set enable with 4 queued bytes (div=2) → four contiguous 20-cycle frames with no idle gap. busy drops after 80 cycles and empty=1.
- Assert reset during the DATA state of a frame → serial_tx_o=1 on the next cycle, STATUS=0x2, no further transitions.
- Write BAUD_DIV=0 → reads back 1. A 0xFF frame then lasts 10 cycles.
